// File: rtl/sha256_byte_host_ctrl_pkg.sv
// Shared types and pin constants for the SHA-256 byte-wide pin protocol.
// Used by the host-side controller and the responder wrapper.
package sha256_pin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_HASH,
        SETTLE,
        READ,
        DONE,
        ERROR
    } state_e;

    localparam int MSG_BYTES    = 64;
    localparam int DIGEST_BYTES = 32;
    localparam int ADDR_W       = 6;

    localparam int WR_BIT    = 6;
    localparam int READY_BIT = 7;

endpackage

// File: rtl/sha256_byte_host_ctrl_if.sv
// Command/result handshakes plus the ASIC pin bundle of the host controller.
// master = controller side, slave = harness / responder side.
interface sha256_byte_host_ctrl_if;
    import sha256_pin_pkg::*;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [MSG_BYTES*8-1:0]      block_in;
    logic                        res_valid;
    logic                        res_ready;
    logic [DIGEST_BYTES*8-1:0]   digest_out;
    logic                        err;
    logic                        busy;
    logic [7:0]                  pin_data;
    logic [ADDR_W-1:0]           pin_addr;
    logic                        pin_wr;
    logic                        pin_hash_ready;
    logic [7:0]                  pin_rd_data;

    modport master (
        input  cmd_valid, block_in, res_ready,
        input  pin_hash_ready, pin_rd_data,
        output cmd_ready, res_valid, digest_out,
        output err, busy,
        output pin_data, pin_addr, pin_wr
    );

    modport slave (
        output cmd_valid, block_in, res_ready,
        output pin_hash_ready, pin_rd_data,
        input  cmd_ready, res_valid, digest_out,
        input  err, busy,
        input  pin_data, pin_addr, pin_wr
    );

endinterface

// File: rtl/sha256_byte_host_ctrl_rd_capture.sv
// Read-return capture: RD_LAT-deep issue delay line and the digest shifter.
// Each returning byte enters at the top, so the first address ends in [7:0].
module sha256_rd_capture
    import sha256_pin_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue,
    input  logic [7:0]                rd_data,
    output logic [DIGEST_BYTES*8-1:0] digest
);

    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic [DIGEST_BYTES*8-1:0] dig_q, dig_d;

    // stage 0 is loaded on the edge that launches the address
    always_comb begin
        vld_d = {vld_q[RD_LAT-2:0], issue};
        dig_d = dig_q;
        if (vld_q[RD_LAT-1]) begin
            dig_d = {rd_data, dig_q[DIGEST_BYTES*8-1:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dig_q <= '0;
        end else begin
            vld_q <= vld_d;
            dig_q <= dig_d;
        end
    end

    assign digest = dig_q;

endmodule

// File: rtl/sha256_byte_host_ctrl.sv
// Host-side initiator: writes a 512-bit block as 64 addressed bytes, waits
// for hash-ready, reads 32 digest bytes back and hands out the digest.
module sha256_byte_host_ctrl
    import sha256_pin_pkg::*;
#(
    parameter int RD_LAT         = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    sha256_byte_host_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES
                               + DIGEST_BYTES + RD_LAT + 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [MSG_BYTES*8-1:0] shreg_q, shreg_d;
    logic [7:0]             pin_data_q, pin_data_d;
    logic [ADDR_W-1:0]      pin_addr_q, pin_addr_d;
    logic                   pin_wr_q, pin_wr_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   res_valid_q, res_valid_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   rd_issue;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        shreg_d    = shreg_q;
        pin_data_d = pin_data_q;
        pin_addr_d = pin_addr_q;
        pin_wr_d   = 1'b0;
        rd_issue   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d    = WRITE;
                    pin_wr_d   = 1'b1;
                    pin_addr_d = '0;
                    pin_data_d = bus.block_in[7:0];
                    shreg_d    = {8'h00, bus.block_in[MSG_BYTES*8-1:8]};
                end
            end
            WRITE: begin
                // address 63 goes last: it kicks off the responder
                if (pin_addr_q == ADDR_W'(MSG_BYTES - 1)) begin
                    state_d = WAIT_HASH;
                    cyc_d   = '0;
                end else begin
                    pin_wr_d   = 1'b1;
                    pin_addr_d = pin_addr_q + ADDR_W'(1);
                    pin_data_d = shreg_q[7:0];
                    shreg_d    = {8'h00, shreg_q[MSG_BYTES*8-1:8]};
                end
            end
            WAIT_HASH: begin
                if (bus.pin_hash_ready) begin
                    state_d = SETTLE;
                    cyc_d   = '0;
                end else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERROR;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            SETTLE: begin
                if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d    = READ;
                    cyc_d      = '0;
                    pin_addr_d = '0;
                    rd_issue   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            READ: begin
                if (cyc_q < CW'(DIGEST_BYTES - 1)) begin
                    pin_addr_d = pin_addr_q + ADDR_W'(1);
                    rd_issue   = 1'b1;
                end
                if (cyc_q == CW'(DIGEST_BYTES + RD_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        err_d       = (state_d == ERROR);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            shreg_q     <= '0;
            pin_data_q  <= '0;
            pin_addr_q  <= '0;
            pin_wr_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            shreg_q     <= shreg_d;
            pin_data_q  <= pin_data_d;
            pin_addr_q  <= pin_addr_d;
            pin_wr_q    <= pin_wr_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    sha256_rd_capture #(
        .RD_LAT (RD_LAT)
    ) u_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .issue   (rd_issue),
        .rd_data (bus.pin_rd_data),
        .digest  (bus.digest_out)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.pin_data  = pin_data_q;
    assign bus.pin_addr  = pin_addr_q;
    assign bus.pin_wr    = pin_wr_q;

endmodule
